// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer counted in 1-second ticks.
// Adds pedestrian green shortening and a night flashing-yellow mode.
module traffic_phase_ctrl #(
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_PED    = 5,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             sec_tick,
  input  logic             night_mode,
  input  logic             ped_req,
  output logic             sec_en,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] remain,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    AR_A  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_B  = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    NIGHT = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] L_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] L_PED    = CNT_W'(T_PED - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             ped_q, ped_d;
  logic             flash_q, flash_d;
  logic             tick, expire, shorten;

  assign tick    = en & sec_tick;
  assign expire  = tick && (remain_q == '0);
  assign shorten = tick && ped_q && (remain_q > L_PED);

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    flash_d  = flash_q;
    ped_d    = ped_q | ped_req;
    if (tick && remain_q != '0)
      remain_d = remain_q - CNT_W'(1);
    unique case (state_q)
      AR_A, AR_B: begin
        if (expire) begin
          if (night_mode) begin
            state_d  = NIGHT;
            remain_d = '0;
            flash_d  = 1'b1;
            ped_d    = 1'b0;
          end else begin
            state_d  = (state_q == AR_A) ? NS_G : EW_G;
            remain_d = L_GREEN;
          end
        end
      end
      NS_G, EW_G: begin
        if (expire) begin
          state_d  = (state_q == NS_G) ? NS_Y : EW_Y;
          remain_d = L_YELLOW;
          ped_d    = ped_req;
        end else if (shorten) begin
          remain_d = L_PED;
          ped_d    = ped_req;
        end
      end
      NS_Y, EW_Y: begin
        if (expire) begin
          state_d  = (state_q == NS_Y) ? AR_B : AR_A;
          remain_d = L_ALLRED;
        end
      end
      NIGHT: begin
        remain_d = '0;
        ped_d    = 1'b0;
        if (tick) begin
          if (!night_mode) begin
            state_d  = AR_A;
            remain_d = L_ALLRED;
            flash_d  = 1'b0;
          end else begin
            flash_d = ~flash_q;
          end
        end
      end
      default: begin
        state_d  = AR_A;
        remain_d = L_ALLRED;
        flash_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q  <= AR_A;
      remain_q <= L_ALLRED;
      ped_q    <= 1'b0;
      flash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      ped_q    <= ped_d;
      flash_q  <= flash_d;
    end
  end

  // Lights depend on registered state only
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    unique case (state_q)
      NS_G:    ns_light = GRN;
      NS_Y:    ns_light = YEL;
      EW_G:    ew_light = GRN;
      EW_Y:    ew_light = YEL;
      NIGHT: begin
        ns_light = {1'b0, flash_q, 1'b0};
        ew_light = {1'b0, flash_q, 1'b0};
      end
      default: ;
    endcase
  end

  assign sec_en = en;
  assign remain = remain_q;
  assign phase  = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: full cycle, pedestrian,
// night mode, freeze and async reset sequences.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rstb;
  logic       en;
  logic       sec_tick;
  logic       night_mode;
  logic       ped_req;
  logic       sec_en;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [6:0] remain;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  traffic_phase_ctrl dut (
    .clk        (clk),
    .rstb       (rstb),
    .en         (en),
    .sec_tick   (sec_tick),
    .night_mode (night_mode),
    .ped_req    (ped_req),
    .sec_en     (sec_en),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .remain     (remain),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       tick;
    logic       night;
    logic       ped;
    logic [2:0] ph;
    logic [6:0] rem;
    logic [2:0] ns;
    logic [2:0] ew;
    string      name;
  } vec_t;

  vec_t vecs[8];

  int         dur[6]  = '{2, 25, 3, 2, 25, 3};
  logic [2:0] ns_t[6] = '{3'b100, 3'b001, 3'b010,
                          3'b100, 3'b100, 3'b100};
  logic [2:0] ew_t[6] = '{3'b100, 3'b100, 3'b100,
                          3'b100, 3'b001, 3'b010};

  task automatic chk(input string name, input logic [2:0] ph,
                     input logic [6:0] rem, input logic [2:0] ns,
                     input logic [2:0] ew);
    checks++;
    if (phase !== ph || remain !== rem || ns_light !== ns ||
        ew_light !== ew || sec_en !== en) begin
      errors++;
      $display("FAIL %s: got ph=%0d rem=%0d ns=%b ew=%b sec_en=%b, want ph=%0d rem=%0d ns=%b ew=%b sec_en=%b",
               name, phase, remain, ns_light, ew_light, sec_en,
               ph, rem, ns, ew, en);
    end
  endtask

  task automatic do_tick();
    sec_tick = 1'b1;
    @(posedge clk); #1;
    sec_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic ped_pulse();
    ped_req = 1'b1;
    @(posedge clk); #1;
    ped_req = 1'b0;
  endtask

  task automatic full_cycle();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < dur[i]; k++) begin
        chk($sformatf("cycle p%0d k%0d", i, k), 3'(i),
            7'(dur[i] - 1 - k), ns_t[i], ew_t[i]);
        do_tick();
      end
    end
    chk("cycle wrap", 3'd0, 7'd1, 3'b100, 3'b100);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 7'd20, 3'b001, 3'b100, "ped1 no tick"};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 7'd4,  3'b001, 3'b100, "ped1 shorten"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 7'd3,  3'b001, 3'b100, "ped dec 3"};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 7'd3,  3'b001, 3'b100, "ped2 no tick"};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 7'd2,  3'b001, 3'b100, "ped2 no effect"};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 7'd1,  3'b001, 3'b100, "ped dec 1"};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 7'd0,  3'b001, 3'b100, "ped dec 0"};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 7'd2,  3'b010, 3'b100, "ped NS_Y"};

    rstb = 1'b1; en = 1'b1; sec_tick = 1'b0;
    night_mode = 1'b0; ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b0;
    chk("reset", 3'd0, 7'd1, 3'b100, 3'b100);

    full_cycle();

    run_ticks(6);
    chk("NS_G rem20", 3'd1, 7'd20, 3'b001, 3'b100);
    foreach (vecs[i]) begin
      en = vecs[i].en; sec_tick = vecs[i].tick;
      night_mode = vecs[i].night; ped_req = vecs[i].ped;
      @(posedge clk); #1;
      sec_tick = 1'b0; ped_req = 1'b0;
      chk(vecs[i].name, vecs[i].ph, vecs[i].rem, vecs[i].ns, vecs[i].ew);
    end
    run_ticks(5);
    chk("EW_G start", 3'd4, 7'd24, 3'b100, 3'b001);
    do_tick();
    chk("ped cleared", 3'd4, 7'd23, 3'b100, 3'b001);

    run_ticks(29);
    chk("NS_G pre-night", 3'd1, 7'd24, 3'b001, 3'b100);
    night_mode = 1'b1;
    run_ticks(25);
    chk("night NS_Y", 3'd2, 7'd2, 3'b010, 3'b100);
    run_ticks(3);
    chk("night AR_B", 3'd3, 7'd1, 3'b100, 3'b100);
    run_ticks(2);
    chk("night entry", 3'd6, 7'd0, 3'b010, 3'b010);
    do_tick();
    chk("night flash off", 3'd6, 7'd0, 3'b000, 3'b000);
    ped_pulse();
    do_tick();
    chk("night flash on", 3'd6, 7'd0, 3'b010, 3'b010);
    night_mode = 1'b0;
    do_tick();
    chk("night exit", 3'd0, 7'd1, 3'b100, 3'b100);
    run_ticks(2);
    chk("post night NS_G", 3'd1, 7'd24, 3'b001, 3'b100);
    do_tick();
    chk("night ped ignored", 3'd1, 7'd23, 3'b001, 3'b100);

    run_ticks(55);
    chk("EW_Y rem1", 3'd5, 7'd1, 3'b100, 3'b010);
    en = 1'b0; sec_tick = 1'b1;
    for (int c = 0; c < 50; c++) begin
      ped_req = (c == 10);
      @(posedge clk); #1;
    end
    ped_req = 1'b0; sec_tick = 1'b0;
    chk("freeze", 3'd5, 7'd1, 3'b100, 3'b010);
    en = 1'b1;
    run_ticks(4);
    chk("thaw NS_G", 3'd1, 7'd24, 3'b001, 3'b100);
    do_tick();
    chk("frozen ped apply", 3'd1, 7'd4, 3'b001, 3'b100);

    run_ticks(13);
    chk("EW_G rem21", 3'd4, 7'd21, 3'b100, 3'b001);
    @(posedge clk);
    #3 rstb = 1'b1;
    #1 chk("async reset", 3'd0, 7'd1, 3'b100, 3'b100);
    @(posedge clk); #1;
    chk("reset held", 3'd0, 7'd1, 3'b100, 3'b100);
    rstb = 1'b0;
    full_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
